// File: rtl/image_stream_writer.sv
// Producer side of the CNN input FIFO: takes one H*W frame from a valid/ready pixel
// stream and writes it in raster order through a single registered output entry.
module image_stream_writer #(
    parameter int H          = 24,
    parameter int W          = 24,
    parameter int DATA_WIDTH = 8,
    localparam int ROW_W     = (H > 1) ? $clog2(H) : 1,
    localparam int COL_W     = (W > 1) ? $clog2(W) : 1,
    localparam int CNT_W     = $clog2(H * W + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_pix_valid,
    input  logic [DATA_WIDTH-1:0] i_pix_data,
    output logic                  o_pix_ready,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_wen,
    output logic [DATA_WIDTH-1:0] o_fifo_wdata,
    output logic [ROW_W-1:0]      o_row,
    output logic [COL_W-1:0]      o_col,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic                    frame_done_q, frame_done_d;

    logic                    fifo_wen;
    logic                    pix_ready;
    logic                    accept;
    logic                    last_pix;

    always_comb begin
        fifo_wen  = out_valid_q & ~i_fifo_full;
        // The entry may be refilled in the same cycle it drains, giving 1 pixel/clk.
        pix_ready = (state_q == S_LOAD) & (~out_valid_q | ~i_fifo_full);
        accept    = i_pix_valid & pix_ready;
        last_pix  = (pix_cnt_q == CNT_W'(H * W - 1));
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;

        if (accept) begin
            out_data_d  = i_pix_data;
            out_valid_d = 1'b1;
        end else if (fifo_wen) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_LOAD;
                    row_d     = '0;
                    col_d     = '0;
                    pix_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (col_q == COL_W'(W - 1)) begin
                        col_d = '0;
                        row_d = (row_q == ROW_W'(H - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Frame is complete only once the final pixel has left the entry.
                if (fifo_wen) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            row_q        <= '0;
            col_q        <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_pix_ready  = pix_ready;
    assign o_fifo_wen   = fifo_wen;
    assign o_fifo_wdata = out_data_q;
    assign o_row        = row_q;
    assign o_col        = col_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_image_stream_writer.sv
// Directed bench for image_stream_writer on a 2x3 frame: streaming, backpressure,
// counter stepping, ignored inputs, mid-frame reset and back-to-back frames.
module tb_image_stream_writer;

    localparam int H  = 2;
    localparam int W  = 3;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          i_start;
    logic          i_pix_valid;
    logic [DW-1:0] i_pix_data;
    logic          o_pix_ready;
    logic          i_fifo_full;
    logic          o_fifo_wen;
    logic [DW-1:0] o_fifo_wdata;
    logic [0:0]    o_row;
    logic [1:0]    o_col;
    logic          o_busy;
    logic          o_frame_done;

    int tests;
    int fails;

    image_stream_writer #(.H(H), .W(W), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_pix_valid  (i_pix_valid),
        .i_pix_data   (i_pix_data),
        .o_pix_ready  (o_pix_ready),
        .i_fifo_full  (i_fifo_full),
        .o_fifo_wen   (o_fifo_wen),
        .o_fifo_wdata (o_fifo_wdata),
        .o_row        (o_row),
        .o_col        (o_col),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_fifo_wen)
            $display("[TB] t=%0t fifo write data=%02h", $time, o_fifo_wdata);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one IDLE cycle with i_start high so the next cycle is in LOAD.
    task automatic start_frame();
        i_start     = 1'b1;
        i_pix_valid = 1'b0;
        i_fifo_full = 1'b0;
        next_cycle();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        i_start     = 1'b0;
        i_pix_valid = 1'b1;
        i_pix_data  = 8'h5A;
        i_fifo_full = 1'b0;
        repeat (2) next_cycle();
        reset       = 1'b0;
        i_pix_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (o_fifo_wen !== 1'b0 || o_pix_ready !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: wen=%b ready=%b busy=%b done=%b, required all 0",
                     o_fifo_wen, o_pix_ready, o_busy, o_frame_done);
        end
        tests++;
        if (o_fifo_wdata !== 8'h00 || o_row !== 1'b0 || o_col !== 2'd0) begin
            fails++;
            $display("FAIL reset_data: wdata=%02h row=%0d col=%0d, required 00/0/0",
                     o_fifo_wdata, o_row, o_col);
        end
        next_cycle();
        i_pix_valid = 1'b0;
    endtask

    // Full-rate frame with pixel values base..base+5; checks every cycle to frame_done.
    task automatic test_back_to_back(input logic [DW-1:0] base);
        logic [DW-1:0] exp_d;
        start_frame();
        for (int c = 0; c < 8; c++) begin
            i_pix_valid = (c < 6);
            i_pix_data  = base + DW'(c);
            @(negedge clk);
            tests++;
            if (o_pix_ready !== (c < 6)) begin
                fails++;
                $display("FAIL b2b_ready c=%0d: got %b required %b", c, o_pix_ready, (c < 6));
            end
            tests++;
            if (o_fifo_wen !== (c >= 1 && c <= 6)) begin
                fails++;
                $display("FAIL b2b_wen c=%0d: got %b required %b", c, o_fifo_wen, (c >= 1 && c <= 6));
            end
            if (c >= 1 && c <= 6) begin
                exp_d = base + DW'(c - 1);
                tests++;
                if (o_fifo_wdata !== exp_d) begin
                    fails++;
                    $display("FAIL b2b_wdata c=%0d: got %02h required %02h", c, o_fifo_wdata, exp_d);
                end
            end
            tests++;
            if (o_frame_done !== (c == 7) || o_busy !== (c < 7)) begin
                fails++;
                $display("FAIL b2b_done_busy c=%0d: done=%b busy=%b required done=%b busy=%b",
                         c, o_frame_done, o_busy, (c == 7), (c < 7));
            end
            next_cycle();
        end
        i_pix_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (o_frame_done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done_pulse: got %b required 0", o_frame_done);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [10:0]   full_v  = 11'b000_0001_1100;
        logic [10:0]   ready_v = 11'b001_1110_0011;
        logic [10:0]   wen_v   = 11'b011_1110_0010;
        int            wd [11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 6};
        int            next_pix = 1;
        int            nwr = 0;
        start_frame();
        for (int c = 0; c < 11; c++) begin
            i_fifo_full = full_v[c];
            i_pix_valid = (next_pix <= 6);
            i_pix_data  = DW'(next_pix);
            @(negedge clk);
            if (o_fifo_wen) nwr++;
            tests++;
            if (o_pix_ready !== ready_v[c]) begin
                fails++;
                $display("FAIL bp_ready c=%0d: got %b required %b", c, o_pix_ready, ready_v[c]);
            end
            tests++;
            if (o_fifo_wen !== wen_v[c]) begin
                fails++;
                $display("FAIL bp_wen c=%0d: got %b required %b", c, o_fifo_wen, wen_v[c]);
            end
            if (c >= 1) begin
                tests++;
                if (o_fifo_wdata !== DW'(wd[c])) begin
                    fails++;
                    $display("FAIL bp_wdata c=%0d: got %02h required %02h", c, o_fifo_wdata, wd[c]);
                end
            end
            tests++;
            if (o_frame_done !== (c == 10) || o_busy !== (c < 10)) begin
                fails++;
                $display("FAIL bp_done_busy c=%0d: done=%b busy=%b required done=%b busy=%b",
                         c, o_frame_done, o_busy, (c == 10), (c < 10));
            end
            next_cycle();
            if (ready_v[c] && next_pix <= 6) next_pix++;
        end
        tests++;
        if (nwr != 6) begin
            fails++;
            $display("FAIL bp_write_count: got %0d required 6", nwr);
        end
        i_pix_valid = 1'b0;
        i_fifo_full = 1'b0;
    endtask

    task automatic test_gappy_counters();
        int            exp_row [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        int            exp_col [13] = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0, 0};
        logic [DW-1:0] exp_d;
        start_frame();
        for (int c = 0; c < 13; c++) begin
            i_pix_valid = (c % 2 == 0) && (c <= 10);
            i_pix_data  = 8'h10 + DW'(c / 2);
            @(negedge clk);
            tests++;
            if (o_row !== 1'(exp_row[c]) || o_col !== 2'(exp_col[c])) begin
                fails++;
                $display("FAIL gap_rowcol c=%0d: got %0d/%0d required %0d/%0d",
                         c, o_row, o_col, exp_row[c], exp_col[c]);
            end
            tests++;
            if (o_fifo_wen !== (c % 2 == 1)) begin
                fails++;
                $display("FAIL gap_wen c=%0d: got %b required %b", c, o_fifo_wen, (c % 2 == 1));
            end
            if (c % 2 == 1) begin
                exp_d = 8'h10 + DW'((c - 1) / 2);
                tests++;
                if (o_fifo_wdata !== exp_d) begin
                    fails++;
                    $display("FAIL gap_wdata c=%0d: got %02h required %02h", c, o_fifo_wdata, exp_d);
                end
            end
            tests++;
            if (o_busy !== (c < 12) || o_frame_done !== (c == 12)) begin
                fails++;
                $display("FAIL gap_busy_done c=%0d: busy=%b done=%b required busy=%b done=%b",
                         c, o_busy, o_frame_done, (c < 12), (c == 12));
            end
            next_cycle();
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        logic [DW-1:0] exp_d;
        int            nwr = 0;
        i_start     = 1'b0;
        i_fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_pix_valid = 1'b1;
            i_pix_data  = 8'hEE;
            @(negedge clk);
            tests++;
            if (o_pix_ready !== 1'b0 || o_fifo_wen !== 1'b0 || o_busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_ignore c=%0d: ready=%b wen=%b busy=%b required 0/0/0",
                         c, o_pix_ready, o_fifo_wen, o_busy);
            end
            next_cycle();
        end
        start_frame();
        for (int c = 0; c < 9; c++) begin
            i_start     = (c >= 1 && c <= 3);
            i_pix_valid = 1'b1;
            i_pix_data  = (c < 6) ? 8'h21 + DW'(c) : 8'hEE;
            @(negedge clk);
            if (o_fifo_wen) nwr++;
            tests++;
            if (o_pix_ready !== (c < 6) || o_fifo_wen !== (c >= 1 && c <= 6)) begin
                fails++;
                $display("FAIL ign_ready_wen c=%0d: ready=%b wen=%b required %b/%b",
                         c, o_pix_ready, o_fifo_wen, (c < 6), (c >= 1 && c <= 6));
            end
            if (c >= 1 && c <= 6) begin
                exp_d = 8'h21 + DW'(c - 1);
                tests++;
                if (o_fifo_wdata !== exp_d) begin
                    fails++;
                    $display("FAIL ign_wdata c=%0d: got %02h required %02h", c, o_fifo_wdata, exp_d);
                end
            end
            tests++;
            if (o_frame_done !== (c == 7) || o_busy !== (c < 7)) begin
                fails++;
                $display("FAIL ign_done_busy c=%0d: done=%b busy=%b required %b/%b",
                         c, o_frame_done, o_busy, (c == 7), (c < 7));
            end
            next_cycle();
        end
        tests++;
        if (nwr != 6) begin
            fails++;
            $display("FAIL ign_write_count: got %0d required 6", nwr);
        end
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        for (int c = 0; c < 3; c++) begin
            i_pix_valid = 1'b1;
            i_pix_data  = 8'h71 + DW'(c);
            next_cycle();
        end
        i_fifo_full = 1'b1;
        i_pix_data  = 8'h74;
        @(negedge clk);
        tests++;
        if (o_fifo_wen !== 1'b0 || o_pix_ready !== 1'b0 || o_fifo_wdata !== 8'h73 ||
            o_row !== 1'b1 || o_col !== 2'd0) begin
            fails++;
            $display("FAIL mid_full_hold: wen=%b ready=%b wdata=%02h row=%0d col=%0d required 0/0/73/1/0",
                     o_fifo_wen, o_pix_ready, o_fifo_wdata, o_row, o_col);
        end
        reset = 1'b1;
        next_cycle();
        reset       = 1'b0;
        i_fifo_full = 1'b0;
        @(negedge clk);
        tests++;
        if (o_fifo_wen !== 1'b0 || o_pix_ready !== 1'b0 || o_busy !== 1'b0 ||
            o_row !== 1'b0 || o_col !== 2'd0 || o_frame_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: wen=%b ready=%b busy=%b row=%0d col=%0d done=%b required all 0",
                     o_fifo_wen, o_pix_ready, o_busy, o_row, o_col, o_frame_done);
        end
        next_cycle();
        i_pix_valid = 1'b0;
        test_back_to_back(8'h81);
    endtask

    task automatic test_start_on_done();
        logic          vld;
        logic          exp_wen;
        logic [DW-1:0] exp_d;
        start_frame();
        for (int c = 0; c < 16; c++) begin
            vld         = (c < 6) || (c >= 8 && c < 14);
            i_pix_valid = vld;
            i_pix_data  = (c < 6) ? 8'h30 + DW'(c) : 8'h40 + DW'(c - 8);
            i_start     = (c == 7);
            @(negedge clk);
            exp_wen = (c >= 1 && c <= 6) || (c >= 9 && c <= 14);
            tests++;
            if (o_pix_ready !== vld || o_fifo_wen !== exp_wen) begin
                fails++;
                $display("FAIL sod_ready_wen c=%0d: ready=%b wen=%b required %b/%b",
                         c, o_pix_ready, o_fifo_wen, vld, exp_wen);
            end
            if (exp_wen) begin
                exp_d = (c <= 6) ? 8'h30 + DW'(c - 1) : 8'h40 + DW'(c - 9);
                tests++;
                if (o_fifo_wdata !== exp_d) begin
                    fails++;
                    $display("FAIL sod_wdata c=%0d: got %02h required %02h", c, o_fifo_wdata, exp_d);
                end
            end
            tests++;
            if (o_frame_done !== (c == 7 || c == 15) || o_busy !== !(c == 7 || c == 15)) begin
                fails++;
                $display("FAIL sod_done_busy c=%0d: done=%b busy=%b required %b/%b",
                         c, o_frame_done, o_busy, (c == 7 || c == 15), !(c == 7 || c == 15));
            end
            next_cycle();
        end
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        i_start     = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        i_fifo_full = 1'b0;
        test_reset();
        test_back_to_back(8'h01);
        test_backpressure();
        test_gappy_counters();
        test_ignored_inputs();
        test_reset_mid_frame();
        test_start_on_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
